// File: rtl/shift_line_nb.sv
// Parametrised multi-bit shift register / delay line with bidirectional shift,
// parallel load, clock enable, synchronous clear and a saturating fill count.
module shift_line_nb #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic [WIDTH*DEPTH-1:0]   load_data,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         q_bwd,
    output logic [WIDTH*DEPTH-1:0]   taps,
    output logic [CW-1:0]            fill,
    output logic                     full
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FWD  = 2'b01,
        MODE_BWD  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [DEPTH-1:0][WIDTH-1:0] stage_nxt;
    logic [CW-1:0]               fill_nxt;
    logic [CW-1:0]               fill_inc;

    // Saturating occupancy increment used by both shift directions.
    assign fill_inc = (fill == CW'(DEPTH)) ? fill : fill + CW'(1);

    // Next-state: every stage reads only pre-edge register values.
    always_comb begin
        stage_nxt = stage;
        fill_nxt  = fill;
        if (clr) begin
            stage_nxt = '0;
            fill_nxt  = '0;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_FWD: begin
                    stage_nxt[0] = d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_nxt[i] = stage[i-1];
                    end
                    fill_nxt = fill_inc;
                end
                MODE_BWD: begin
                    stage_nxt[DEPTH-1] = d;
                    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                        stage_nxt[i] = stage[i+1];
                    end
                    fill_nxt = fill_inc;
                end
                MODE_LOAD: begin
                    stage_nxt = load_data;
                    fill_nxt  = CW'(DEPTH);
                end
                default: begin
                    stage_nxt = stage;
                    fill_nxt  = fill;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
            fill  <= '0;
        end else begin
            stage <= stage_nxt;
            fill  <= fill_nxt;
        end
    end

    assign taps  = stage;
    assign q     = stage[DEPTH-1];
    assign q_bwd = stage[0];
    assign full  = (fill == CW'(DEPTH));

endmodule

// File: tb/tb_shift_line_nb.sv
// Self-checking bench for shift_line_nb: directed plan plus randomized traffic
// compared against a queue-based reference model.
module tb_shift_line_nb;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned CWT = $clog2(D + 1);

    logic               clk;
    logic               rst;
    logic               en;
    logic               clr;
    logic [1:0]         mode;
    logic [W-1:0]       d;
    logic [W*D-1:0]     load_data;
    logic [W-1:0]       q;
    logic [W-1:0]       q_bwd;
    logic [W*D-1:0]     taps;
    logic [CWT-1:0]     fill;
    logic               full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mq[$];
    int           mfill;

    shift_line_nb #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .d         (d),
        .load_data (load_data),
        .q         (q),
        .q_bwd     (q_bwd),
        .taps      (taps),
        .fill      (fill),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < int'(D); i++) mq.push_back('0);
        mfill = 0;
    endtask

    // Reference: index i of mq is stage i; shifts are queue push/pop.
    task automatic model_step();
        if (clr) begin
            model_reset();
        end else if (en) begin
            case (mode)
                2'b01: begin
                    mq.push_front(d);
                    void'(mq.pop_back());
                    mfill = (mfill + 1 > int'(D)) ? int'(D) : mfill + 1;
                end
                2'b10: begin
                    mq.push_back(d);
                    void'(mq.pop_front());
                    mfill = (mfill + 1 > int'(D)) ? int'(D) : mfill + 1;
                end
                2'b11: begin
                    for (int i = 0; i < int'(D); i++) mq[i] = load_data[i*W +: W];
                    mfill = int'(D);
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_model(input string tag);
        logic [W*D-1:0] exp_taps;
        for (int i = 0; i < int'(D); i++) exp_taps[i*W +: W] = mq[i];
        check({tag, ".taps"},  64'(taps),  64'(exp_taps));
        check({tag, ".q"},     64'(q),     64'(mq[D-1]));
        check({tag, ".q_bwd"}, 64'(q_bwd), 64'(mq[0]));
        check({tag, ".fill"},  64'(fill),  64'(mfill));
        check({tag, ".full"},  64'(full),  64'(mfill == int'(D)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic drive(input logic e, input logic c, input logic [1:0] m, input logic [W-1:0] dv);
        en = e; clr = c; mode = m; d = dv;
    endtask

    logic [W-1:0] fwd_seq[4];
    logic [W*D-1:0] saved;

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; d = '0; load_data = '0;
        model_reset();
        #12;
        check("reset.taps", 64'(taps), 64'h0);
        check("reset.fill", 64'(fill), 64'h0);
        check("reset.full", 64'(full), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Forward latency: q stays 0 until the 4th shift.
        fwd_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'b01, fwd_seq[i]);
            tick("fwd");
            if (i == 0) check("fwd.no_ripple", 64'(taps), 64'h0000_00A1);
            if (i < 3)  check("fwd.q_zero", 64'(q), 64'h0);
        end
        check("fwd.taps4", 64'(taps), 64'hA1A2_A3A4);
        check("fwd.q4",    64'(q),    64'hA1);
        check("fwd.fill4", 64'(fill), 64'd4);
        check("fwd.full4", 64'(full), 64'd1);

        // Saturation
        drive(1'b1, 1'b0, 2'b01, 8'hB1); tick("sat");
        drive(1'b1, 1'b0, 2'b01, 8'hB2); tick("sat");
        check("sat.q",    64'(q),    64'hA3);
        check("sat.fill", 64'(fill), 64'd4);

        // Load then backward shift
        load_data = 32'h4433_2211;
        drive(1'b1, 1'b0, 2'b11, 8'h00); tick("load");
        check("load.taps", 64'(taps), 64'h4433_2211);
        drive(1'b1, 1'b0, 2'b10, 8'h55); tick("bwd");
        check("bwd.taps",  64'(taps),  64'h5544_3322);
        check("bwd.q_bwd", 64'(q_bwd), 64'h22);

        // Enable low holds everything
        saved = taps;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b01, W'(8'hC0 + i));
            tick("en0");
        end
        check("en0.taps", 64'(taps), 64'(saved));

        // Clear ignores en, and beats load
        drive(1'b0, 1'b1, 2'b01, 8'hEE); tick("clr_en0");
        check("clr_en0.taps", 64'(taps), 64'h0);
        check("clr_en0.fill", 64'(fill), 64'h0);
        load_data = 32'hDEAD_BEEF;
        drive(1'b1, 1'b0, 2'b11, 8'h00); tick("reload");
        drive(1'b1, 1'b1, 2'b11, 8'h00); tick("clr_load");
        check("clr_load.taps", 64'(taps), 64'h0);

        // Hold mode with changing d
        drive(1'b1, 1'b0, 2'b01, 8'h5A); tick("pre_hold");
        saved = taps;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 2'b00, W'($urandom));
            tick("hold");
        end
        check("hold.taps", 64'(taps), 64'(saved));
        check("hold.fill", 64'(fill), 64'd1);

        // Asynchronous reset mid-cycle after loading nonzero data
        load_data = 32'h1234_5678;
        drive(1'b1, 1'b0, 2'b11, 8'h00); tick("pre_rst");
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        #2 rst = 1'b1;
        #1;
        check("async_rst.taps", 64'(taps), 64'h0);
        check("async_rst.fill", 64'(fill), 64'h0);
        check("async_rst.full", 64'(full), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            load_data = W*D'({$urandom, $urandom});
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                  2'($urandom_range(0, 3)), W'($urandom));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
